fetch_stage: RTL and testbench

//  IF stage of the 5-stage RV32 pipeline; drives fd_pc/fd_instr into decode. Holds the PC,

---
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Brief  : RV32 IF stage - PC, icache request, 1-entry response buffer, IF/ID.
// Rev    : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        dcache_stall_i,
    input  logic        mul_stall_i,
    input  logic        load_stall_i,
    input  logic        branch_stall_i,
    input  logic        branch_en_i,
    input  logic [31:0] branch_pc_i,
    output logic        ic_req_o,
    output logic [31:0] ic_addr_o,
    input  logic        ic_valid_i,
    input  logic [31:0] ic_rdata_i,
    output logic        icache_stall_o,
    output logic [31:0] fd_pc_o,
    output logic [31:0] fd_instr_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUF  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fd_pc_q, fd_pc_d;
    logic [31:0] fd_instr_q, fd_instr_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] w_instr_in;
    logic        w_pipe_frozen;
    logic        w_dec_hold;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fd_pc_q    <= 32'h0;
            fd_instr_q <= BUBBLE;
            ibuf_q     <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fd_pc_q    <= fd_pc_d;
            fd_instr_q <= fd_instr_d;
            ibuf_q     <= ibuf_d;
        end
    end

    assign w_pipe_frozen  = dcache_stall_i | mul_stall_i;
    assign w_dec_hold     = load_stall_i | branch_stall_i;
    assign ic_req_o       = (state_q == REQ);
    assign ic_addr_o      = pc_q;
    assign icache_stall_o = (state_q == IDLE) | ((state_q == REQ) & !ic_valid_i);
    assign w_instr_in     = (state_q == BUF) ? ibuf_q : ic_rdata_i;
    assign fd_pc_o        = fd_pc_q;
    assign fd_instr_o     = fd_instr_q;

    always_comb begin
        // IDLE always advances to REQ; no rule below can change that.
        state_d    = (state_q == IDLE) ? REQ : state_q;
        pc_d       = pc_q;
        fd_pc_d    = fd_pc_q;
        fd_instr_d = fd_instr_q;
        ibuf_d     = ibuf_q;

        if (w_pipe_frozen) begin
            if ((state_q == REQ) && ic_valid_i) begin
                ibuf_d  = ic_rdata_i;
                state_d = BUF;
            end
        end else if (icache_stall_o) begin
            // Waiting on an outstanding miss; a pending redirect is retried later.
        end else if (branch_en_i) begin
            fd_pc_d    = 32'h0;
            fd_instr_d = BUBBLE;
            pc_d       = {branch_pc_i[31:2], 2'b00};
            state_d    = REQ;
        end else if (w_dec_hold) begin
            if (state_q == REQ) begin
                ibuf_d  = ic_rdata_i;
                state_d = BUF;
            end
        end else begin
            fd_pc_d    = pc_q;
            fd_instr_d = w_instr_in;
            pc_d       = pc_q + 32'd4;
            state_d    = REQ;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Brief  : Directed self-checking bench for fetch_stage.
// Rev    : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_BUBBLE = 32'h0000_0013;
    localparam logic [31:0] C_JUNK   = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        dcache_stall, mul_stall, load_stall, branch_stall, branch_en;
    logic [31:0] branch_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_rdata;
    logic        icache_stall;
    logic [31:0] fd_pc, fd_instr;

    int passed = 0;
    int total  = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .BUBBLE   (C_BUBBLE)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .dcache_stall_i (dcache_stall),
        .mul_stall_i    (mul_stall),
        .load_stall_i   (load_stall),
        .branch_stall_i (branch_stall),
        .branch_en_i    (branch_en),
        .branch_pc_i    (branch_pc),
        .ic_req_o       (ic_req),
        .ic_addr_o      (ic_addr),
        .ic_valid_i     (ic_valid),
        .ic_rdata_i     (ic_rdata),
        .icache_stall_o (icache_stall),
        .fd_pc_o        (fd_pc),
        .fd_instr_o     (fd_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dcache_stall = 0; mul_stall = 0; load_stall = 0;
        branch_stall = 0; branch_en = 0; branch_pc = 32'h0; ic_valid = 0; ic_rdata = 32'h0;
        cyc(); cyc();
        total++; if (fd_pc !== 32'h0) $display("FAIL reset_fd_pc got %h exp %h", fd_pc, 32'h0); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL reset_fd_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        total++; if (ic_req !== 1'b0) $display("FAIL reset_ic_req got %b exp 0", ic_req); else passed++;
        total++; if (icache_stall !== 1'b1) $display("FAIL reset_icache_stall got %b exp 1", icache_stall); else passed++;
        total++; if (ic_addr !== 32'h0) $display("FAIL reset_ic_addr got %h exp %h", ic_addr, 32'h0); else passed++;
    endtask

    task automatic test_hit_stream();
        rst_n = 1'b1; ic_valid = 1'b1; ic_rdata = 32'hA5A5_0000;
        #1;
        total++; if (icache_stall !== 1'b1) $display("FAIL t1_idle_stall got %b exp 1", icache_stall); else passed++;
        cyc();
        total++; if (ic_req !== 1'b1) $display("FAIL t1_req got %b exp 1", ic_req); else passed++;
        total++; if (icache_stall !== 1'b0) $display("FAIL t1_stall got %b exp 0", icache_stall); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL t1_idle_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        cyc();
        total++; if (fd_pc !== 32'h0) $display("FAIL t1_pc0 got %h exp %h", fd_pc, 32'h0); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0000) $display("FAIL t1_instr0 got %h exp %h", fd_instr, 32'hA5A5_0000); else passed++;
        total++; if (ic_addr !== 32'h4) $display("FAIL t1_addr4 got %h exp %h", ic_addr, 32'h4); else passed++;
        ic_rdata = 32'hA5A5_0004;
        cyc();
        total++; if (fd_pc !== 32'h4) $display("FAIL t1_pc4 got %h exp %h", fd_pc, 32'h4); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0004) $display("FAIL t1_instr4 got %h exp %h", fd_instr, 32'hA5A5_0004); else passed++;
        ic_rdata = 32'hA5A5_0008;
        cyc();
        total++; if (fd_pc !== 32'h8) $display("FAIL t1_pc8 got %h exp %h", fd_pc, 32'h8); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0008) $display("FAIL t1_instr8 got %h exp %h", fd_instr, 32'hA5A5_0008); else passed++;
        total++; if (ic_addr !== 32'hC) $display("FAIL t1_addrC got %h exp %h", ic_addr, 32'hC); else passed++;
    endtask

    task automatic test_miss();
        ic_valid = 1'b0; ic_rdata = C_JUNK;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (icache_stall !== 1'b1) $display("FAIL t2_stall[%0d] got %b exp 1", i, icache_stall); else passed++;
            total++; if (ic_addr !== 32'hC) $display("FAIL t2_addr[%0d] got %h exp %h", i, ic_addr, 32'hC); else passed++;
            cyc();
            total++; if (fd_pc !== 32'h8) $display("FAIL t2_hold[%0d] got %h exp %h", i, fd_pc, 32'h8); else passed++;
        end
        ic_valid = 1'b1; ic_rdata = 32'hA5A5_000C;
        #1;
        total++; if (icache_stall !== 1'b0) $display("FAIL t2_hit_stall got %b exp 0", icache_stall); else passed++;
        cyc();
        total++; if (fd_pc !== 32'hC) $display("FAIL t2_pcC got %h exp %h", fd_pc, 32'hC); else passed++;
        total++; if (fd_instr !== 32'hA5A5_000C) $display("FAIL t2_instrC got %h exp %h", fd_instr, 32'hA5A5_000C); else passed++;
        total++; if (ic_addr !== 32'h10) $display("FAIL t2_addr10 got %h exp %h", ic_addr, 32'h10); else passed++;
    endtask

    task automatic test_redirect();
        ic_rdata = 32'hA5A5_0010; branch_en = 1'b1; branch_pc = 32'h0000_0103;
        cyc();
        total++; if (fd_pc !== 32'h0) $display("FAIL t3_bub_pc got %h exp %h", fd_pc, 32'h0); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL t3_bub_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        total++; if (ic_addr !== 32'h100) $display("FAIL t3_target got %h exp %h", ic_addr, 32'h100); else passed++;
        total++; if (ic_req !== 1'b1) $display("FAIL t3_req got %b exp 1", ic_req); else passed++;
        branch_en = 1'b0; ic_rdata = 32'hA5A5_0100;
        cyc();
        total++; if (fd_pc !== 32'h100) $display("FAIL t3_pc100 got %h exp %h", fd_pc, 32'h100); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0100) $display("FAIL t3_instr100 got %h exp %h", fd_instr, 32'hA5A5_0100); else passed++;
    endtask

    task automatic test_buffer();
        mul_stall = 1'b1; ic_valid = 1'b1; ic_rdata = 32'hA5A5_0104;
        cyc();
        total++; if (ic_req !== 1'b0) $display("FAIL t4_buf_req got %b exp 0", ic_req); else passed++;
        total++; if (fd_pc !== 32'h100) $display("FAIL t4_hold_pc got %h exp %h", fd_pc, 32'h100); else passed++;
        total++; if (ic_addr !== 32'h104) $display("FAIL t4_hold_addr got %h exp %h", ic_addr, 32'h104); else passed++;
        ic_valid = 1'b0; ic_rdata = C_JUNK;
        #1;
        total++; if (icache_stall !== 1'b0) $display("FAIL t4_buf_stall got %b exp 0", icache_stall); else passed++;
        cyc();
        total++; if (fd_pc !== 32'h100) $display("FAIL t4_hold2_pc got %h exp %h", fd_pc, 32'h100); else passed++;
        mul_stall = 1'b0;
        #1;
        total++; if (ic_req !== 1'b0) $display("FAIL t4_no_extra_req got %b exp 0", ic_req); else passed++;
        cyc();
        total++; if (fd_pc !== 32'h104) $display("FAIL t4_pc104 got %h exp %h", fd_pc, 32'h104); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0104) $display("FAIL t4_buf_instr got %h exp %h", fd_instr, 32'hA5A5_0104); else passed++;
        total++; if (ic_addr !== 32'h108) $display("FAIL t4_addr108 got %h exp %h", ic_addr, 32'h108); else passed++;
        total++; if (ic_req !== 1'b1) $display("FAIL t4_req_again got %b exp 1", ic_req); else passed++;
    endtask

    task automatic test_load_stall();
        load_stall = 1'b1; ic_valid = 1'b1; ic_rdata = 32'hA5A5_0108;
        cyc();
        total++; if (fd_pc !== 32'h104) $display("FAIL t5_hold_pc got %h exp %h", fd_pc, 32'h104); else passed++;
        total++; if (ic_req !== 1'b0) $display("FAIL t5_buf_req got %b exp 0", ic_req); else passed++;
        load_stall = 1'b0; ic_rdata = C_JUNK;
        cyc();
        total++; if (fd_pc !== 32'h108) $display("FAIL t5_pc108 got %h exp %h", fd_pc, 32'h108); else passed++;
        total++; if (fd_instr !== 32'hA5A5_0108) $display("FAIL t5_instr108 got %h exp %h", fd_instr, 32'hA5A5_0108); else passed++;
        load_stall = 1'b1; branch_en = 1'b1; branch_pc = 32'h200; ic_rdata = 32'hA5A5_010C;
        cyc();
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL t5_redir_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        total++; if (ic_addr !== 32'h200) $display("FAIL t5_redir_addr got %h exp %h", ic_addr, 32'h200); else passed++;
        load_stall = 1'b0; branch_en = 1'b0;
    endtask

    task automatic test_redirect_during_miss();
        ic_valid = 1'b0; ic_rdata = C_JUNK; branch_en = 1'b1; branch_pc = 32'h40;
        cyc(); cyc();
        total++; if (ic_addr !== 32'h200) $display("FAIL t6_miss_addr got %h exp %h", ic_addr, 32'h200); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL t6_miss_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        ic_valid = 1'b1; ic_rdata = 32'hA5A5_0200;
        cyc();
        total++; if (ic_addr !== 32'h40) $display("FAIL t6_redir_addr got %h exp %h", ic_addr, 32'h40); else passed++;
        total++; if (fd_pc !== 32'h0) $display("FAIL t6_drop_pc got %h exp %h", fd_pc, 32'h0); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL t6_drop_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        branch_pc = 32'hFFFF_FFFC;
        cyc();
        total++; if (ic_addr !== 32'hFFFF_FFFC) $display("FAIL t6_top_addr got %h exp %h", ic_addr, 32'hFFFF_FFFC); else passed++;
        branch_en = 1'b0; ic_rdata = 32'h5A5A_FFFC;
        cyc();
        total++; if (fd_pc !== 32'hFFFF_FFFC) $display("FAIL t6_top_pc got %h exp %h", fd_pc, 32'hFFFF_FFFC); else passed++;
        total++; if (fd_instr !== 32'h5A5A_FFFC) $display("FAIL t6_top_instr got %h exp %h", fd_instr, 32'h5A5A_FFFC); else passed++;
        total++; if (ic_addr !== 32'h0) $display("FAIL t6_wrap_addr got %h exp %h", ic_addr, 32'h0); else passed++;
    endtask

    task automatic test_reset_mid_miss();
        ic_valid = 1'b0; ic_rdata = C_JUNK;
        cyc();
        rst_n = 1'b0;
        #1;
        total++; if (ic_req !== 1'b0) $display("FAIL rm_req got %b exp 0", ic_req); else passed++;
        total++; if (fd_pc !== 32'h0) $display("FAIL rm_fd_pc got %h exp %h", fd_pc, 32'h0); else passed++;
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL rm_fd_instr got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        cyc();
        rst_n = 1'b1; ic_valid = 1'b1;
        cyc();
        total++; if (fd_instr !== C_BUBBLE) $display("FAIL rm_idle_ignore got %h exp %h", fd_instr, C_BUBBLE); else passed++;
        total++; if (ic_addr !== 32'h0) $display("FAIL rm_idle_addr got %h exp %h", ic_addr, 32'h0); else passed++;
    endtask

    initial begin
        test_reset();
        test_hit_stream();
        test_miss();
        test_redirect();
        test_buffer();
        test_load_stall();
        test_redirect_during_miss();
        test_reset_mid_miss();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
